// File: rtl/mms_scheduler.sv
// Min-max zero-sequence injection for three sign-magnitude Q12.12 phase references,
// using one shared multiplier and one shared adder. Define MMS_SAT_EN to saturate instead of wrap.
module mms_scheduler #(
   parameter int N = 24,
   parameter int Q = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] UA,
   input  logic [N-1:0] UB,
   input  logic [N-1:0] UC,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] outUA,
   output logic [N-1:0] outUB,
   output logic [N-1:0] outUC,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy
);

`ifdef MMS_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   localparam logic [N-1:0] K1   = N'(24'h001279);
   localparam logic [N-1:0] K2   = {1'b1, (N-1)'(23'h000800)};
   localparam logic [N-2:0] MAXM = '1;
   localparam int           PW   = 2 * (N - 1);

   typedef enum logic [3:0] {
      IDLE, MUL_A, MUL_B, MUL_C, MINMAX, HALF, ADD_A, ADD_B, ADD_C, OUT
   } state_t;

   state_t       state_q, state_d;
   logic [N-1:0] ua_q, ub_q, uc_q, ua_d, ub_d, uc_d;
   logic [N-1:0] ma_q, mb_q, mc_q, ma_d, mb_d, mc_d;
   logic [N-1:0] s_q, h_q, s_d, h_d;
   logic [N-1:0] oa_q, ob_q, oc_q, oa_d, ob_d, oc_d;

   logic [N-1:0]    mul_a, mul_b, mul_res;
   logic [PW-1:0]   prod;
   logic [PW-Q-1:0] prod_sh;
   logic [N-2:0]    mul_mag;

   logic [N-1:0]        add_a, add_b, add_res, max_v, min_v;
   logic [N-1:0]        sum;
   logic [N-2:0]        add_mag;
   logic                add_sgn;
   logic signed [N-1:0] sa, sb, sc;

   function automatic logic signed [N-1:0] sm_to_s(input logic [N-1:0] v);
      logic signed [N-1:0] m;
      m = $signed({1'b0, v[N-2:0]});
      return v[N-1] ? -m : m;
   endfunction

   // Signed view of the products so min/max order by value, not by raw bits
   always_comb begin
      sa = sm_to_s(ma_q);
      sb = sm_to_s(mb_q);
      sc = sm_to_s(mc_q);
      max_v = mc_q;
      min_v = mc_q;
      if (sa >= sb && sa >= sc)  max_v = ma_q;
      else if (sb >= sc)         max_v = mb_q;
      if (sa <= sb && sa <= sc)  min_v = ma_q;
      else if (sb <= sc)         min_v = mb_q;
   end

   // Shared multiplier
   always_comb begin
      mul_b = K1;
      case (state_q)
         MUL_A:   mul_a = ua_q;
         MUL_B:   mul_a = ub_q;
         MUL_C:   mul_a = uc_q;
         default: begin
            mul_a = s_q;
            mul_b = K2;
         end
      endcase
      prod    = {{(N-1){1'b0}}, mul_a[N-2:0]} * {{(N-1){1'b0}}, mul_b[N-2:0]};
      prod_sh = (PW-Q)'(prod >> Q);
      mul_mag = (SAT_EN && |prod_sh[PW-Q-1:N-1]) ? MAXM : prod_sh[N-2:0];
      mul_res = {(mul_a[N-1] ^ mul_b[N-1]) & |mul_mag, mul_mag};
   end

   // Shared adder
   always_comb begin
      add_b = h_q;
      case (state_q)
         MINMAX: begin
            add_a = max_v;
            add_b = min_v;
         end
         ADD_A:   add_a = ma_q;
         ADD_B:   add_a = mb_q;
         default: add_a = mc_q;
      endcase
      sum = {1'b0, add_a[N-2:0]} + {1'b0, add_b[N-2:0]};
      if (add_a[N-1] == add_b[N-1]) begin
         add_mag = (SAT_EN && sum[N-1]) ? MAXM : sum[N-2:0];
         add_sgn = add_a[N-1];
      end else if (add_a[N-2:0] >= add_b[N-2:0]) begin
         add_mag = add_a[N-2:0] - add_b[N-2:0];
         add_sgn = add_a[N-1];
      end else begin
         add_mag = add_b[N-2:0] - add_a[N-2:0];
         add_sgn = add_b[N-1];
      end
      add_res = {add_sgn & |add_mag, add_mag};
   end

   always_comb begin
      state_d = state_q;
      ua_d = ua_q;  ub_d = ub_q;  uc_d = uc_q;
      ma_d = ma_q;  mb_d = mb_q;  mc_d = mc_q;
      s_d  = s_q;   h_d  = h_q;
      oa_d = oa_q;  ob_d = ob_q;  oc_d = oc_q;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = MUL_A;
            ua_d = UA;  ub_d = UB;  uc_d = UC;
         end
         MUL_A:  begin ma_d = mul_res; state_d = MUL_B;  end
         MUL_B:  begin mb_d = mul_res; state_d = MUL_C;  end
         MUL_C:  begin mc_d = mul_res; state_d = MINMAX; end
         MINMAX: begin s_d  = add_res; state_d = HALF;   end
         HALF:   begin h_d  = mul_res; state_d = ADD_A;  end
         ADD_A:  begin oa_d = add_res; state_d = ADD_B;  end
         ADD_B:  begin ob_d = add_res; state_d = ADD_C;  end
         ADD_C:  begin oc_d = add_res; state_d = OUT;    end
         OUT:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ua_q <= '0;  ub_q <= '0;  uc_q <= '0;
         ma_q <= '0;  mb_q <= '0;  mc_q <= '0;
         s_q  <= '0;  h_q  <= '0;
         oa_q <= '0;  ob_q <= '0;  oc_q <= '0;
      end else begin
         state_q <= state_d;
         ua_q <= ua_d;  ub_q <= ub_d;  uc_q <= uc_d;
         ma_q <= ma_d;  mb_q <= mb_d;  mc_q <= mc_d;
         s_q  <= s_d;   h_q  <= h_d;
         oa_q <= oa_d;  ob_q <= ob_d;  oc_q <= oc_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == OUT);
   assign busy      = (state_q != IDLE);
   assign outUA     = oa_q;
   assign outUB     = ob_q;
   assign outUC     = oc_q;

endmodule
